// File: rtl/mem_stage.sv
// MIPS memory-access stage: data-memory req/ack bus, byte-lane steering, load extension.
// Define MEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses without a bus cycle.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_in,
    input  logic [4:0]  dest_in,
    input  logic [5:0]  op_in,
    input  logic [7:0]  signals_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] data_out,
    output logic [4:0]  dest_out,
    output logic [5:0]  op_out,
    output logic [7:0]  signals_out,
    output logic        mem_err_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        req_q;
    logic        err_q;
    logic [5:0]  op_q;
    logic [4:0]  dest_q;
    logic [7:0]  sig_q;
    logic [7:0]  cnt_q;

    logic        is_mem;
    logic        misal;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_d;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [7:0]  cnt_d;
    logic        expired;

    assign is_mem = valid_in & (signals_in[1] | signals_in[2]);

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_in;
        case (op_in)
            6'h20, 6'h24, 6'h28: begin
                be_d    = 4'b0001 << addr_in[1:0];
                wdata_d = {4{store_in[7:0]}};
            end
            6'h21, 6'h25, 6'h29: begin
                be_d    = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_in[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misal = 1'b0;
        case (op_in)
            6'h21, 6'h25, 6'h29: misal = addr_in[0];
            6'h23, 6'h2B:        misal = |addr_in[1:0];
            default: ;
        endcase
    end
`else
    assign misal = 1'b0;
`endif

    always_comb begin
        lane_byte = dmem_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    lane_byte = dmem_rdata[15:8];
            2'd2:    lane_byte = dmem_rdata[23:16];
            2'd3:    lane_byte = dmem_rdata[31:24];
            default: ;
        endcase
    end

    assign lane_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_d = dmem_rdata;
        case (op_q)
            6'h20:   load_d = {{24{lane_byte[7]}}, lane_byte};
            6'h24:   load_d = {24'd0, lane_byte};
            6'h21:   load_d = {{16{lane_half[15]}}, lane_half};
            6'h25:   load_d = {16'd0, lane_half};
            default: ;
        endcase
        if (we_q)
            load_d = 32'd0;
    end

    // Saturating wait counter; expiry is judged on the value it is about to take.
    assign cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign expired = (cnt_d >= TMO);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= '0;
            dest_q   <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        addr_q   <= addr_in;
                        be_q     <= be_d;
                        wdata_q  <= wdata_d;
                        we_q     <= signals_in[2];
                        op_q     <= op_in;
                        dest_q   <= dest_in;
                        cnt_q    <= '0;
                        result_q <= '0;
                        if (misal) begin
                            err_q   <= 1'b1;
                            sig_q   <= {signals_in[7:1], 1'b0};
                            state_q <= RESP;
                        end else begin
                            err_q   <= 1'b0;
                            sig_q   <= signals_in;
                            req_q   <= 1'b1;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (dmem_ack) begin
                        req_q    <= 1'b0;
                        result_q <= load_d;
                        state_q  <= RESP;
                    end else if (expired) begin
                        req_q    <= 1'b0;
                        result_q <= '0;
                        err_q    <= 1'b1;
                        sig_q[0] <= 1'b0;
                        state_q  <= RESP;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_out   = (state_q == WAIT) || (state_q == IDLE && is_mem);
    assign valid_out   = (state_q == RESP) || (state_q == IDLE && valid_in && !is_mem);
    assign data_out    = (state_q == RESP) ? result_q : addr_in;
    assign dest_out    = (state_q == RESP) ? dest_q : dest_in;
    assign op_out      = (state_q == RESP) ? op_q : op_in;
    assign signals_out = (state_q == RESP) ? sig_q : signals_in;
    assign mem_err_out = (state_q == RESP) && err_q;

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads, stores, timeout, reset and alignment cases.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] addr_in;
    logic [31:0] store_in;
    logic [4:0]  dest_in;
    logic [5:0]  op_in;
    logic [7:0]  signals_in;
    logic        stall_out;
    logic        valid_out;
    logic [31:0] data_out;
    logic [4:0]  dest_out;
    logic [5:0]  op_out;
    logic [7:0]  signals_out;
    logic        mem_err_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    mem_stage #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in),
        .addr_in(addr_in), .store_in(store_in), .dest_in(dest_in),
        .op_in(op_in), .signals_in(signals_in), .stall_out(stall_out),
        .valid_out(valid_out), .data_out(data_out), .dest_out(dest_out),
        .op_out(op_out), .signals_out(signals_out),
        .mem_err_out(mem_err_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic [5:0]  op;
        logic [7:0]  sig;
        logic        err;
    } exp_t;

    exp_t q[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitor: every valid output must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && valid_out) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data_out", data_out, e.data);
                check("dest_out", 32'(dest_out), 32'(e.dest));
                check("op_out", 32'(op_out), 32'(e.op));
                check("signals_out", 32'(signals_out), 32'(e.sig));
                check("mem_err_out", 32'(mem_err_out), 32'(e.err));
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_we"}, 32'(dmem_we), 32'd0);
        check({tag, "_be"}, 32'(dmem_be), 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_stall"}, 32'(stall_out), 32'd0);
        check({tag, "_err"}, 32'(mem_err_out), 32'd0);
    endtask

    task automatic mem_access(
        input string tag, input logic [5:0] op, input logic [31:0] addr,
        input logic [31:0] st, input logic [4:0] dest, input logic [7:0] sig,
        input int lat, input logic [31:0] rdata,
        input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
        input logic [31:0] e_wdata, input logic [31:0] e_data,
        input logic e_err, input logic [7:0] e_sig, input int e_stalls);
        exp_t e;
        int   stalls;
        int   nreq;
        bit   done;
        e.data = e_data; e.dest = dest; e.op = op; e.sig = e_sig; e.err = e_err;
        q.push_back(e);
        @(posedge clock); #1;
        valid_in = 1'b1; op_in = op; addr_in = addr; store_in = st;
        dest_in = dest; signals_in = sig;
        @(negedge clock);
        check({tag, "_issue_stall"}, 32'(stall_out), 32'd1);
        check({tag, "_issue_req"}, 32'(dmem_req), 32'd0);
        stalls = 1;
        nreq   = 0;
        done   = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clock); #1;
            dmem_ack = 1'b0;
            @(negedge clock);
            if (valid_out) begin
                done = 1'b1;
            end else begin
                if (stall_out) stalls++;
                if (dmem_req) begin
                    nreq++;
                    if (nreq == 1) begin
                        check({tag, "_addr"}, dmem_addr, e_addr);
                        check({tag, "_be"}, 32'(dmem_be), 32'(e_be));
                        check({tag, "_we"}, 32'(dmem_we), 32'(e_we));
                        if (e_we) check({tag, "_wdata"}, dmem_wdata, e_wdata);
                    end
                    if (nreq == lat) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = rdata;
                    end
                end
            end
        end
        if (!done) begin
            check({tag, "_resp_timeout"}, 32'd0, 32'd1);
            void'(q.pop_back());
        end
        check({tag, "_stalls"}, 32'(stalls), 32'(e_stalls));
        check({tag, "_nreq"}, 32'(nreq), 32'(e_stalls - 1));
        check({tag, "_resp_stall"}, 32'(stall_out), 32'd0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; valid_in = 1'b0; addr_in = '0; store_in = '0;
        dest_in = '0; op_in = '0; signals_in = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle("reset");

        // Pass-through, zero latency.
        e.data = 32'h12345678; e.dest = 5'd3; e.op = 6'h00;
        e.sig = 8'h01; e.err = 1'b0;
        q.push_back(e);
        @(posedge clock); #1;
        valid_in = 1'b1; op_in = 6'h00; addr_in = 32'h12345678;
        dest_in = 5'd3; signals_in = 8'h01;
        @(negedge clock);
        check("pass_stall", 32'(stall_out), 32'd0);
        check("pass_req", 32'(dmem_req), 32'd0);
        @(posedge clock); #1;
        valid_in = 1'b0;
        @(negedge clock);
        check("bubble_valid", 32'(valid_out), 32'd0);

        mem_access("lb", 6'h20, 32'h103, 32'h0, 5'd5, 8'hA3, 3, 32'h80FFFFFF,
                   32'h100, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 8'hA3, 4);
        mem_access("sh", 6'h29, 32'h202, 32'h0000ABCD, 5'd0, 8'h04, 1, 32'h0,
                   32'h200, 4'b1100, 1'b1, 32'hABCDABCD, 32'h0, 1'b0, 8'h04, 2);
        mem_access("lh", 6'h21, 32'h102, 32'h0, 5'd7, 8'h03, 2, 32'h80017FFF,
                   32'h100, 4'b1100, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 8'h03, 3);
        mem_access("lhu", 6'h25, 32'h100, 32'h0, 5'd8, 8'h03, 1, 32'h1234F00D,
                   32'h100, 4'b0011, 1'b0, 32'h0, 32'h0000F00D, 1'b0, 8'h03, 2);
        mem_access("lbu", 6'h24, 32'h101, 32'h0, 5'd9, 8'h03, 1, 32'h00009A00,
                   32'h100, 4'b0010, 1'b0, 32'h0, 32'h0000009A, 1'b0, 8'h03, 2);
        mem_access("sb", 6'h28, 32'h501, 32'h000000A5, 5'd0, 8'h04, 1, 32'h0,
                   32'h500, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 8'h04, 2);
        mem_access("rw", 6'h2B, 32'h600, 32'h11223344, 5'd1, 8'h07, 2, 32'hFFFFFFFF,
                   32'h600, 4'b1111, 1'b1, 32'h11223344, 32'h0, 1'b0, 8'h07, 3);
        mem_access("tmo", 6'h23, 32'h40, 32'h0, 5'd4, 8'h0B, 0, 32'h0,
                   32'h40, 4'b1111, 1'b0, 32'h0, 32'h0, 1'b1, 8'h0A, 5);
`ifdef MEM_ALIGN_CHECK_EN
        mem_access("mis", 6'h23, 32'h301, 32'h0, 5'd2, 8'h03, 1, 32'hDEADBEEF,
                   32'h300, 4'b1111, 1'b0, 32'h0, 32'h0, 1'b1, 8'h02, 1);
`else
        mem_access("mis", 6'h23, 32'h301, 32'h0, 5'd2, 8'h03, 1, 32'hDEADBEEF,
                   32'h300, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 8'h03, 2);
`endif

        // Reset during the second WAIT cycle, late ack must be ignored.
        @(posedge clock); #1;
        valid_in = 1'b1; op_in = 6'h23; addr_in = 32'h400;
        dest_in = 5'd6; signals_in = 8'h03;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_pre_req", 32'(dmem_req), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0; valid_in = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clock);
        check_idle("rst_mid");
        @(posedge clock); #1;
        dmem_ack = 1'b0;
        @(negedge clock);
        check("rst_ack_req", 32'(dmem_req), 32'd0);
        check("rst_ack_valid", 32'(valid_out), 32'd0);
        check("rst_ack_stall", 32'(stall_out), 32'd0);

        repeat (2) @(posedge clock);
        check("sb_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register. Loads and stores go out on a data-memory bus with a req/ack handshake. Load data is aligned and extended, and the pipeline stalls while an access is in flight. Non-memory instructions pass straight through to the MEM/WB register with their ALU result.

## Interface
- `TIMEOUT`, 255: ack wait limit in cycles (1..255); on expiry the access is aborted.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_in` in 1: EX/MEM holds a valid instruction.
- `addr_in` in 32: ALU result (effective address, or result for non-memory ops).
- `store_in` in 32: rt value for stores.
- `dest_in` in 5: destination register.
- `op_in` in 6: opcode.
- `signals_in` in 8: control bundle. Bit0 reg_write, bit1 mem_read, bit2 mem_write; bits 7:3 pass through untouched.
- `stall_out` out 1: upstream must hold EX/MEM contents.
- `valid_out` out 1: outputs are valid for MEM/WB.
- `data_out` out 32: load result or ALU result.
- `dest_out` out 5, `op_out` out 6, `signals_out` out 8: to MEM/WB.
- `mem_err_out` out 1: timeout or misalignment on the current output.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (word-aligned), `dmem_be` out 4, `dmem_wdata` out 32.
- `dmem_ack` in 1, `dmem_rdata` in 32.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE, non-memory op or `valid_in`=0:** combinational pass-through.
  - `valid_out`=`valid_in`, `data_out`=`addr_in`, other fields pass through.
  - `stall_out`=0.
- **IDLE, `valid_in` with mem_read or mem_write:**
  - `stall_out`=1 combinationally; `valid_out`=0.
  - Latch address, byte enables, write data, op, dest and signals; go to WAIT.
- **WAIT:**
  - `dmem_req`=1, with bus fields held stable from the latched values; `stall_out`=1; `valid_out`=0.
  - On `dmem_ack`: format `dmem_rdata` into the result register (stores: result is 0) and go to RESP.
  - Timeout counter increments each WAIT cycle. When it reaches `TIMEOUT` without ack: result=0, set error, clear reg_write in latched signals, go to RESP.
- **RESP:**
  - `valid_out`=1; outputs come from the latched registers; `stall_out`=0.
  - Inputs are ignored this cycle, because they still hold the completed instruction.
  - Next state IDLE.
- **Byte lanes, little-endian, lane = addr[1:0]:**
  - lb/lbu/sb (0x20/0x24/0x28): be = 0001<<lane; store byte replicated to all four lanes.
  - lh/lhu/sh (0x21/0x25/0x29): be = 0011 if addr[1]=0, else 1100; store half replicated.
  - lw/sw (0x23/0x2B): be = 1111.
  - Loads: the selected lane is shifted to bit 0. lb/lh sign-extend; lbu/lhu zero-extend.
  - `dmem_addr` = {addr[31:2],2'b00}.
- **Other conditions:**
  - mem_read and mem_write both set: treated as a store.
  - An ack seen outside WAIT is ignored.

## Timing
- **Reset values:** state IDLE. `dmem_req`, `dmem_we`, `valid_out`, `stall_out`, `mem_err_out` = 0. `dmem_be`=0; `dmem_addr`, `dmem_wdata` = 0. Latched registers and the counter = 0.
- **Reset mid-access:** `dmem_req` drops on the cycle after reset is sampled, and any later ack is ignored.
- **Non-memory latency:** 0 cycles added.
- **Memory latency:** 1 issue cycle + N WAIT cycles + 1 RESP cycle, where N is the ack latency (N≥1, since `dmem_req` first rises in WAIT).
- **Bus protocol:** `dmem_req` stays asserted until the cycle ack is sampled, and deasserts in RESP. Back-to-back accesses therefore have at least one idle bus cycle.
- **Timeout:** the counter is 8 bits, clears on entry to WAIT, and saturates.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Halfword with addr[0]≠0, or word with addr[1:0]≠0, issues no bus request.
  - FSM goes IDLE→RESP directly, with `mem_err_out`=1, reg_write cleared and `data_out`=0.
- Undefined:
  - Low address bits beyond the access size are ignored; halfwords use addr[1] only, words use lane 0.
  - `mem_err_out` reports timeout only.

## Test plan
- **Pass-through:** valid_in=1, op=0x00, addr_in=0x12345678, signals=0x01 → same cycle valid_out=1, data_out=0x12345678, stall_out=0, dmem_req never asserted.
- **lb sign-extension:** lb at addr 0x103, ack after 3 cycles with rdata=0x80FF_FFFF → dmem_addr=0x100, be=1000, data_out=0xFFFF_FF80. stall_out is high for 4 cycles, then RESP for 1 cycle.
- **sh, upper half:** sh at addr 0x202, store_in=0x0000_ABCD → dmem_we=1, be=1100, wdata=0xABCD_ABCD; data_out=0 in RESP.
- **Timeout:** TIMEOUT=4 with no ack → RESP after 4 WAIT cycles with mem_err_out=1, signals_out bit0=0, data_out=0.
- **Reset mid-WAIT:** reset asserted in the 2nd WAIT cycle, with ack arriving 1 cycle later → all outputs at reset values, FSM in IDLE, ack ignored.
- **Misaligned word:** with `MEM_ALIGN_CHECK_EN`, lw at 0x301 → no dmem_req, RESP on the next cycle with mem_err_out=1. Without the macro → normal access at 0x300, be=1111.
